div_scheduler: RTL
==================

# div_scheduler

Time-multiplexes the single shared sequential divider across up to `NUM_VOICES` oscillator voices. It sits between the per-voice oscillators/frequency dividers and the sequential divider. On every `sample_now` tick it issues one divide job per active voice and collects the quotients into an output frame. The waveshaper/mixer stage then reads that frame.

## Interface
- `NUM_VOICES`, 4: number of voices served per frame (1..8).
- `CNT_W`, 16: width of oscillator count and divider operands.
- `Q_W`, 8: quotient width returned by the divider.
- `TIMEOUT`, 64: max cycles to wait for `div_done` per job.

Ports:
- `clk` in 1: system clock (12 MHz on FPGA).
- `n_rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `en` in 1: block enable. Low aborts the current frame.
- `sample_now` in 1: one-cycle frame-start pulse from `clock_div`.
- `voice_active` in NUM_VOICES: per-voice active flags.
- `count_flat` in NUM_VOICES*CNT_W: oscillator counts. Voice i is at bits [i*CNT_W +: CNT_W].
- `divider_flat` in NUM_VOICES*CNT_W: per-voice divider values, same packing as `count_flat`.
- `div_start` out 1: one-cycle job-start pulse to the divider.
- `div_count` out CNT_W: dividend for the issued job.
- `div_divider` out CNT_W: divisor for the issued job.
- `div_done` in 1: one-cycle pulse from the divider. `div_q` is valid in the same cycle.
- `div_q` in Q_W: quotient result.
- `q_flat` out NUM_VOICES*Q_W: committed quotient frame.
- `frame_valid` out 1: one-cycle pulse when `q_flat` updates.
- `overrun` out 1: one-cycle pulse when `sample_now` arrives while the block is busy.
- `timeout` out 1: one-cycle pulse when a job is abandoned.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, SCAN, ISSUE, WAIT, COMMIT.
- **IDLE:** on `sample_now` with `en` = 1:
  - latch `voice_active` into `mask`;
  - clear the shadow quotient registers;
  - set index = 0;
  - go to SCAN.
- **SCAN** (one cycle per index evaluated):
  - Eligible voice: if `mask[idx]` = 1 and `divider[idx]` ≠ 0, go to ISSUE.
  - Otherwise: shadow[idx] = 0 and index is incremented.
  - When index reaches `NUM_VOICES`, go to COMMIT.
- **ISSUE:**
  - Drive `div_count`/`div_divider` from voice idx, sampling the live operands this cycle.
  - Assert `div_start` for 1 cycle.
  - Go to WAIT and clear the watchdog counter.
- **WAIT:**
  - On `div_done`: shadow[idx] = `div_q`, idx++, go to SCAN.
  - If the watchdog reaches `TIMEOUT`: shadow[idx] = 0, pulse `timeout`, idx++, go to SCAN.
  - Hold `div_count`/`div_divider` stable for the whole of WAIT.
- **COMMIT:** copy all shadow registers to `q_flat` atomically, pulse `frame_valid`, go to IDLE.
- **`en` low in any state:**
  - go to IDLE next cycle;
  - `q_flat` holds its last committed value;
  - no `frame_valid` is produced;
  - `div_done` arriving afterwards is ignored.
- **`sample_now` while busy:** ignored, `overrun` pulses, and the current frame continues.
- **`sample_now` coincident with COMMIT:** counts as busy, so `overrun` pulses.
- **`div_done` outside WAIT:** ignored.
- **Reset values:** state IDLE; every output and register 0.

## Timing
- **Frame start:** `sample_now` high in cycle t (IDLE) → SCAN at t+1.
- **First eligible voice 0:**
  - ISSUE at t+2;
  - `div_start` high in cycle t+2;
  - WAIT from t+3.
- **Ineligible voices:** each costs 1 SCAN cycle.
- **Per active voice:** 2 cycles (SCAN, ISSUE) + divider latency (cycles from `div_start` to `div_done`).
- **Frame end:** `frame_valid` and the `q_flat` update occur in the COMMIT cycle, which is the cycle after the last index is evaluated.
- **All voices inactive:** `frame_valid` at t+1+NUM_VOICES+1.
- **Watchdog:** counts WAIT cycles. Timeout fires in the cycle the count equals `TIMEOUT`, so that is the last WAIT cycle.
- **Output behaviour:** all outputs are registered, so no combinational paths reach outputs. `div_start`, `frame_valid`, `overrun` and `timeout` are exactly 1 cycle wide.

## Test plan
- **Four active voices, divider model with 10-cycle latency:**
  - stimulus: counts 100/200/300/400, dividers 4/8/12/16, model returns q = count/divider;
  - required: 4 `div_start` pulses, then one `frame_valid` with q_flat = {25,25,25,25}, `busy` low the next cycle.
- **Mask 4'b0101 with voice 1's divider = 0:**
  - stimulus: mask 4'b0101, divider[1] = 0;
  - required: only voices 0 and 2 issued; q[1] = q[3] = 0; all-zero mask gives `frame_valid` 6 cycles after `sample_now`.
- **Second `sample_now` mid-frame:**
  - stimulus: second `sample_now` 5 cycles after the first;
  - required: `overrun` pulses once, exactly one `frame_valid`, job sequence unchanged.
- **Divider never responds on voice 2:**
  - stimulus: no `div_done` for voice 2;
  - required: `timeout` pulses after 64 WAIT cycles, q[2] = 0, voice 3 still issued and committed.
- **`en` drop / reset during WAIT of voice 1:**
  - stimulus: drop `en` (or assert `n_rst` low) during voice 1's WAIT;
  - required: IDLE next cycle, no `frame_valid`, `q_flat` equal to the previous frame (or 0 after reset), late `div_done` ignored.

Source files
------------

// File: rtl/div_scheduler.sv
// div_scheduler
//
// Shares one sequential divider across NUM_VOICES oscillator voices. Each
// sample_now tick starts a frame. The frame issues one divide job per
// eligible voice, which is a voice that is active with a non-zero divider.
// The quotients collect in shadow registers and are committed to q_flat
// together at the end of the frame.
//
// Ports
//   clk, n_rst           system clock, async active-low reset
//   en                   block enable; low aborts the frame in progress
//   sample_now           one-cycle frame-start pulse
//   voice_active         per-voice active flags (latched at frame start)
//   count_flat           per-voice dividends, voice i at [i*CNT_W +: CNT_W]
//   divider_flat         per-voice divisors, same packing
//   div_start            one-cycle job-start pulse to the divider
//   div_count/_divider   operands of the issued job, held through WAIT
//   div_done, div_q      divider completion pulse and quotient
//   q_flat               committed quotient frame, voice i at [i*Q_W +: Q_W]
//   frame_valid          one-cycle pulse in the cycle q_flat updates
//   overrun              sample_now arrived while a frame was in progress
//   timeout              a job was abandoned by the watchdog
//   busy                 high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | waiting for sample_now with en high
// SCAN   | evaluate voice r_idx; r_idx == NUM_VOICES ends the frame
// ISSUE  | div_start pulse, operands presented to the divider
// WAIT   | waiting for div_done under the watchdog
// COMMIT | shadow quotients visible on q_flat, frame_valid high

module div_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int CNT_W      = 16,
    parameter int Q_W        = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        en,
    input  logic                        sample_now,
    input  logic [NUM_VOICES-1:0]       voice_active,
    input  logic [NUM_VOICES*CNT_W-1:0] count_flat,
    input  logic [NUM_VOICES*CNT_W-1:0] divider_flat,
    output logic                        div_start,
    output logic [CNT_W-1:0]            div_count,
    output logic [CNT_W-1:0]            div_divider,
    input  logic                        div_done,
    input  logic [Q_W-1:0]              div_q,
    output logic [NUM_VOICES*Q_W-1:0]   q_flat,
    output logic                        frame_valid,
    output logic                        overrun,
    output logic                        timeout,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_VOICES + 1);
    localparam int SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_VOICES);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic             TO_FIRST = (TIMEOUT == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NUM_VOICES-1:0]     r_mask;
    logic [IDX_W-1:0]          r_idx;
    logic [WD_W-1:0]           r_wd;
    logic [Q_W-1:0]            r_shadow [NUM_VOICES];

    logic                      r_div_start;
    logic [CNT_W-1:0]          r_div_count;
    logic [CNT_W-1:0]          r_div_divider;
    logic [NUM_VOICES*Q_W-1:0] r_q_flat;
    logic                      r_frame_valid;
    logic                      r_overrun;
    logic                      r_timeout;
    logic                      r_busy;

    logic [CNT_W-1:0]          w_count   [NUM_VOICES];
    logic [CNT_W-1:0]          w_divider [NUM_VOICES];
    logic [SEL_W-1:0]          w_sel;

    logic                      w_start;
    logic                      w_skip;
    logic                      w_issue;
    logic                      w_done_ok;
    logic                      w_abandon;
    logic                      w_commit;
    logic                      w_to_pre;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
        assign w_count[g]   = count_flat[g*CNT_W +: CNT_W];
        assign w_divider[g] = divider_flat[g*CNT_W +: CNT_W];
    end

    // Only used while r_idx < NUM_VOICES, so the truncation is safe.
    assign w_sel = r_idx[SEL_W-1:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_skip      = 1'b0;
        w_issue     = 1'b0;
        w_done_ok   = 1'b0;
        w_abandon   = 1'b0;
        w_commit    = 1'b0;
        w_to_pre    = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sample_now) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (r_idx == IDX_END) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_COMMIT;
                    end else if (r_mask[w_sel] && (w_divider[w_sel] != '0)) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_skip      = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    w_state_nxt = ST_WAIT;
                    w_to_pre    = TO_FIRST;
                end
                ST_WAIT: begin
                    // r_wd == 0 marks the TIMEOUT-th WAIT cycle. The timeout
                    // pulse is already on the output in that cycle, so the job
                    // is abandoned even if div_done arrives in the same cycle.
                    // That keeps timeout and the committed quotient consistent.
                    if (r_wd == '0) begin
                        w_abandon   = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else if (div_done) begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_to_pre    = (r_wd == WD_ONE);
                    end
                end
                ST_COMMIT: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mask        <= '0;
            r_idx         <= '0;
            r_wd          <= '0;
            r_div_start   <= 1'b0;
            r_div_count   <= '0;
            r_div_divider <= '0;
            r_q_flat      <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_div_start   <= w_issue;
            r_frame_valid <= w_commit;
            r_timeout     <= w_to_pre;
            r_overrun     <= sample_now && (r_state != ST_IDLE);
            r_busy        <= (w_state_nxt != ST_IDLE);

            if (w_start) begin
                r_mask <= voice_active;
                r_idx  <= '0;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_shadow[i] <= '0;
                end
            end

            if (w_skip) begin
                r_shadow[w_sel] <= '0;
                r_idx           <= r_idx + IDX_ONE;
            end

            // The operands are registered at the SCAN->ISSUE edge. They stay
            // untouched until the next issue, so they are stable through WAIT.
            if (w_issue) begin
                r_div_count   <= w_count[w_sel];
                r_div_divider <= w_divider[w_sel];
            end

            if (r_state == ST_ISSUE) begin
                r_wd <= WD_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wd != '0)) begin
                r_wd <= r_wd - WD_ONE;
            end

            if (w_done_ok) begin
                r_shadow[w_sel] <= div_q;
                r_idx           <= r_idx + IDX_ONE;
            end

            if (w_abandon) begin
                r_shadow[w_sel] <= '0;
                r_idx           <= r_idx + IDX_ONE;
            end

            if (w_commit) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_q_flat[i*Q_W +: Q_W] <= r_shadow[i];
                end
            end
        end
    end

    assign div_start   = r_div_start;
    assign div_count   = r_div_count;
    assign div_divider = r_div_divider;
    assign q_flat      = r_q_flat;
    assign frame_valid = r_frame_valid;
    assign overrun     = r_overrun;
    assign timeout     = r_timeout;
    assign busy        = r_busy;

endmodule
